// File: rtl/ram_arb_stn2tft_if.sv
// Request/grant and RAM-side signal bundle for the STN2TFT frame-RAM arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface ram_arb_stn2tft_if;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;

    // Capture write port
    logic          cap_req;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic          cap_gnt;

    // Display read port
    logic          dsp_req;
    logic [AW-1:0] dsp_addr;
    logic          dsp_gnt;
    logic [DW-1:0] dsp_rdata;
    logic          dsp_rvld;

    // Host port
    logic          hst_req;
    logic          hst_we;
    logic [AW-1:0] hst_addr;
    logic [DW-1:0] hst_wdata;
    logic          hst_gnt;
    logic [DW-1:0] hst_rdata;
    logic          hst_rvld;

    // RAM port
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    // Error reporting
    logic          err_clr;
    logic          oor_err;

    modport slave (
        input  cap_req, cap_addr, cap_wdata,
        output cap_gnt,
        input  dsp_req, dsp_addr,
        output dsp_gnt, dsp_rdata, dsp_rvld,
        input  hst_req, hst_we, hst_addr, hst_wdata,
        output hst_gnt, hst_rdata, hst_rvld,
        output ram_ce, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        input  err_clr,
        output oor_err
    );

    modport master (
        output cap_req, cap_addr, cap_wdata,
        input  cap_gnt,
        output dsp_req, dsp_addr,
        input  dsp_gnt, dsp_rdata, dsp_rvld,
        output hst_req, hst_we, hst_addr, hst_wdata,
        input  hst_gnt, hst_rdata, hst_rvld,
        input  ram_ce, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        output err_clr,
        input  oor_err
    );
endinterface

// File: rtl/ram_arb_stn2tft.sv
// Single-port frame-RAM arbiter/sequencer for STN2TFT: capture writes, display reads, host access.
// Define ARB_AGING_EN to let starved capture/host requests overtake the display stream.
module ram_arb_stn2tft #(
    parameter int unsigned RAM_DEPTH = 6144,
    parameter int unsigned AGE_LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst_x,
    ram_arb_stn2tft_if.slave bus
);
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] AGE_MAX = CW'(AGE_LIMIT);
`ifdef ARB_AGING_EN
    localparam bit AGING_EN = 1'b1;
`else
    localparam bit AGING_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_DSP  = 2'd1,
        SRC_CAP  = 2'd2,
        SRC_HST  = 2'd3
    } src_e;

    src_e          src_c;
    logic          xfer_c;
    logic          in_range_c;
    logic          sel_we_c;
    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] sel_wdata_c;

    logic [CW-1:0] cap_age;
    logic [CW-1:0] hst_age;
    logic          cap_aged_c;
    logic          hst_aged_c;

    logic          ram_ce_q;
    logic          ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic          oor_err_q;

    // Read tag pipeline: stage 0 tracks the RAM access cycle, stage 1 the RAM output cycle
    logic [1:0]    tag_vld;
    logic [1:0]    tag_hst;
    logic [1:0]    tag_oor;

    logic          dsp_rvld_q;
    logic          hst_rvld_q;
    logic [DW-1:0] dsp_rdata_q;
    logic [DW-1:0] hst_rdata_q;

`ifdef ARB_AGING_EN
    // Saturating starvation counters; cleared on grant or when the request drops
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            cap_age <= '0;
            hst_age <= '0;
        end else begin
            if (!bus.cap_req || (src_c == SRC_CAP)) begin
                cap_age <= '0;
            end else if (cap_age != AGE_MAX) begin
                cap_age <= cap_age + CW'(1);
            end
            if (!bus.hst_req || (src_c == SRC_HST)) begin
                hst_age <= '0;
            end else if (hst_age != AGE_MAX) begin
                hst_age <= hst_age + CW'(1);
            end
        end
    end
`else
    assign cap_age = '0;
    assign hst_age = '0;
`endif

    assign cap_aged_c = AGING_EN && bus.cap_req && (cap_age == AGE_MAX);
    assign hst_aged_c = AGING_EN && bus.hst_req && (hst_age == AGE_MAX);

    // Winner selection: aged cap, aged hst, then dsp > cap > hst
    always_comb begin
        src_c = SRC_NONE;
        if (!rst_x) begin
            src_c = SRC_NONE;
        end else if (cap_aged_c) begin
            src_c = SRC_CAP;
        end else if (hst_aged_c) begin
            src_c = SRC_HST;
        end else if (bus.dsp_req) begin
            src_c = SRC_DSP;
        end else if (bus.cap_req) begin
            src_c = SRC_CAP;
        end else if (bus.hst_req) begin
            src_c = SRC_HST;
        end
    end

    // Winning requester's access; display reads carry no data so the write bus holds
    always_comb begin
        sel_addr_c  = bus.dsp_addr;
        sel_wdata_c = ram_wdata_q;
        sel_we_c    = 1'b0;
        case (src_c)
            SRC_CAP: begin
                sel_addr_c  = bus.cap_addr;
                sel_wdata_c = bus.cap_wdata;
                sel_we_c    = 1'b1;
            end
            SRC_HST: begin
                sel_addr_c  = bus.hst_addr;
                sel_wdata_c = bus.hst_wdata;
                sel_we_c    = bus.hst_we;
            end
            default: begin
                sel_addr_c  = bus.dsp_addr;
                sel_wdata_c = ram_wdata_q;
                sel_we_c    = 1'b0;
            end
        endcase
    end

    assign xfer_c     = (src_c != SRC_NONE);
    assign in_range_c = (32'(sel_addr_c) < RAM_DEPTH);

    // RAM control registers and sticky out-of-range flag (set beats clear)
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            oor_err_q   <= 1'b0;
        end else begin
            ram_ce_q <= xfer_c && in_range_c;
            ram_we_q <= xfer_c && sel_we_c;
            if (xfer_c) begin
                ram_addr_q  <= sel_addr_c;
                ram_wdata_q <= sel_wdata_c;
            end
            if (xfer_c && !in_range_c) begin
                oor_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                oor_err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            tag_vld <= '0;
            tag_hst <= '0;
            tag_oor <= '0;
        end else begin
            tag_vld[0] <= xfer_c && !sel_we_c;
            tag_hst[0] <= (src_c == SRC_HST);
            tag_oor[0] <= !in_range_c;
            tag_vld[1] <= tag_vld[0];
            tag_hst[1] <= tag_hst[0];
            tag_oor[1] <= tag_oor[0];
        end
    end

    // Read return: out-of-range reads deliver zero instead of stale RAM output
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            dsp_rvld_q  <= 1'b0;
            hst_rvld_q  <= 1'b0;
            dsp_rdata_q <= '0;
            hst_rdata_q <= '0;
        end else begin
            dsp_rvld_q <= tag_vld[1] && !tag_hst[1];
            hst_rvld_q <= tag_vld[1] && tag_hst[1];
            if (tag_vld[1] && !tag_hst[1]) begin
                dsp_rdata_q <= tag_oor[1] ? '0 : bus.ram_rdata;
            end
            if (tag_vld[1] && tag_hst[1]) begin
                hst_rdata_q <= tag_oor[1] ? '0 : bus.ram_rdata;
            end
        end
    end

    assign bus.dsp_gnt   = (src_c == SRC_DSP);
    assign bus.cap_gnt   = (src_c == SRC_CAP);
    assign bus.hst_gnt   = (src_c == SRC_HST);
    assign bus.ram_ce    = ram_ce_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.oor_err   = oor_err_q;
    assign bus.dsp_rvld  = dsp_rvld_q;
    assign bus.dsp_rdata = dsp_rdata_q;
    assign bus.hst_rvld  = hst_rvld_q;
    assign bus.hst_rdata = hst_rdata_q;
endmodule

// File: tb/tb_ram_arb_stn2tft.sv
// Self-checking bench for ram_arb_stn2tft: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level model with a read-return queue.
`timescale 1ns/1ps
module tb_ram_arb_stn2tft;
    localparam int unsigned DEPTH = 6144;
    localparam int unsigned AGE   = 15;

    logic clk = 1'b0;
    logic rst_x = 1'b1;
    always #5 clk = ~clk;

    ram_arb_stn2tft_if bus();

    ram_arb_stn2tft #(.RAM_DEPTH(DEPTH), .AGE_LIMIT(AGE)) dut (
        .clk   (clk),
        .rst_x (rst_x),
        .bus   (bus.slave)
    );

    // Physical RAM behind the arbiter
    logic [7:0] ram_mem [0:8191];
    always @(posedge clk) begin
        if (bus.ram_ce) begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        bit         hst;
        bit         ok;
        logic [7:0] data;
    } rd_t;

    int         cyc;
    bit   [7:0] mmem   [8192];
    bit         mknown [8192];
    rd_t        rq[$];
    int         m_cap_age, m_hst_age;
    logic       e_ce, e_we, e_oor;
    logic [12:0] e_addr;
    logic [7:0] e_wdata, e_drd, e_hrd;
    bit         e_drd_ok, e_hrd_ok;
    bit         seen_d, seen_c, seen_h;
    bit         last_gc, last_gh, last_gd;

    task automatic model_reset();
        rq.delete();
        m_cap_age = 0; m_hst_age = 0;
        e_ce = 0; e_we = 0; e_oor = 0; e_addr = '0; e_wdata = '0;
        e_drd = '0; e_hrd = '0; e_drd_ok = 1; e_hrd_ok = 1;
        last_gc = 0; last_gh = 0; last_gd = 0;
    endtask

    function automatic void exp_grants(output bit gd, output bit gc, output bit gh);
        bit ac, ah;
        gd = 0; gc = 0; gh = 0; ac = 0; ah = 0;
`ifdef ARB_AGING_EN
        ac = bus.cap_req && (m_cap_age == AGE);
        ah = bus.hst_req && (m_hst_age == AGE);
`endif
        if (rst_x) begin
            if (ac)               gc = 1;
            else if (ah)          gh = 1;
            else if (bus.dsp_req) gd = 1;
            else if (bus.cap_req) gc = 1;
            else if (bus.hst_req) gh = 1;
        end
    endfunction

    // Apply the access granted this cycle to the expected state after the coming edge
    task automatic model_step(input bit gd, input bit gc, input bit gh);
        int unsigned a;
        bit inr, wr;
        rd_t r;
        if (gd | gc | gh) begin
            a   = gd ? int'(bus.dsp_addr) : gc ? int'(bus.cap_addr) : int'(bus.hst_addr);
            inr = (a < DEPTH);
            wr  = gc ? 1'b1 : gh ? bus.hst_we : 1'b0;
            e_ce = inr; e_we = wr; e_addr = 13'(a);
            if (gc) e_wdata = bus.cap_wdata;
            if (gh) e_wdata = bus.hst_wdata;
            if (wr) begin
                if (inr) begin mmem[a] = e_wdata; mknown[a] = 1; end
            end else begin
                r.due = cyc + 3; r.hst = gh;
                r.ok = !inr || mknown[a];
                r.data = inr ? mmem[a] : 8'h00;
                rq.push_back(r);
            end
            if (!inr) e_oor = 1;
            else if (bus.err_clr) e_oor = 0;
        end else begin
            e_ce = 0; e_we = 0;
            if (bus.err_clr) e_oor = 0;
        end
`ifdef ARB_AGING_EN
        m_cap_age = (bus.cap_req && !gc) ? ((m_cap_age == AGE) ? AGE : m_cap_age + 1) : 0;
        m_hst_age = (bus.hst_req && !gh) ? ((m_hst_age == AGE) ? AGE : m_hst_age + 1) : 0;
`endif
    endtask

    task automatic check_regs();
        bit ed, eh;
        rd_t r;
        ed = 0; eh = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.hst) begin eh = 1; e_hrd = r.data; e_hrd_ok = r.ok; end
            else       begin ed = 1; e_drd = r.data; e_drd_ok = r.ok; end
        end
        chk("ram_ce", bus.ram_ce, e_ce);
        chk("ram_we", bus.ram_we, e_we);
        chk("ram_addr", bus.ram_addr, e_addr);
        chk("ram_wdata", bus.ram_wdata, e_wdata);
        chk("oor_err", bus.oor_err, e_oor);
        chk("dsp_rvld", bus.dsp_rvld, ed);
        chk("hst_rvld", bus.hst_rvld, eh);
        if (e_drd_ok) chk("dsp_rdata", bus.dsp_rdata, e_drd);
        if (e_hrd_ok) chk("hst_rdata", bus.hst_rdata, e_hrd);
    endtask

    // One clock: inputs already driven after a falling edge; returns at the next falling edge
    task automatic tick();
        bit gd, gc, gh;
        #1;
        exp_grants(gd, gc, gh);
        chk("dsp_gnt", bus.dsp_gnt, gd);
        chk("cap_gnt", bus.cap_gnt, gc);
        chk("hst_gnt", bus.hst_gnt, gh);
        seen_d = bus.dsp_gnt; seen_c = bus.cap_gnt; seen_h = bus.hst_gnt;
        model_step(gd, gc, gh);
        last_gd = gd; last_gc = gc; last_gh = gh;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_regs();
    endtask

    function automatic logic [12:0] rand_addr();
        if ($urandom_range(7) == 0) return 13'(DEPTH + $urandom_range(8191 - DEPTH));
        return 13'($urandom_range(63));
    endfunction

    // Pending (requested, not yet granted) accesses keep address and data stable
    task automatic rand_inputs(input int dsp_pct);
        if (!(bus.dsp_req && !last_gd)) begin
            bus.dsp_req  = ($urandom_range(99) < dsp_pct);
            bus.dsp_addr = rand_addr();
        end
        if (!(bus.cap_req && !last_gc)) begin
            bus.cap_req   = ($urandom_range(99) < 40);
            bus.cap_addr  = rand_addr();
            bus.cap_wdata = 8'($urandom);
        end
        if (!(bus.hst_req && !last_gh)) begin
            bus.hst_req   = ($urandom_range(99) < 40);
            bus.hst_we    = 1'($urandom);
            bus.hst_addr  = rand_addr();
            bus.hst_wdata = 8'($urandom);
        end
        bus.err_clr = ($urandom_range(9) == 0);
    endtask

    task automatic idle_inputs();
        bus.dsp_req = 0; bus.cap_req = 0; bus.hst_req = 0; bus.err_clr = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int denied;
        bit granted;
        cyc = 0;
        idle_inputs();
        bus.dsp_addr = '0; bus.cap_addr = '0; bus.cap_wdata = '0;
        bus.hst_we = 0; bus.hst_addr = '0; bus.hst_wdata = '0;
        model_reset();

        // Reset state, grants held low even with requests pending
        #2 rst_x = 1'b0;
        bus.dsp_req = 1;
        repeat (2) @(negedge clk);
        chk("rst_dsp_gnt", bus.dsp_gnt, 0);
        chk("rst_ram_ce", bus.ram_ce, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_oor_err", bus.oor_err, 0);
        chk("rst_dsp_rvld", bus.dsp_rvld, 0);
        bus.dsp_req = 0;
        rst_x = 1'b1;

        // Capture write then display read-back
        bus.cap_req = 1; bus.cap_addr = 13'h0123; bus.cap_wdata = 8'hA5;
        tick();
        chk("t1_cap_gnt", seen_c, 1);
        chk("t1_ram_we", bus.ram_we, 1);
        chk("t1_ram_addr", bus.ram_addr, 13'h0123);
        chk("t1_ram_wdata", bus.ram_wdata, 8'hA5);
        bus.cap_req = 0; bus.dsp_req = 1; bus.dsp_addr = 13'h0123;
        tick();
        chk("t1_rd_we", bus.ram_we, 0);
        chk("t1_rd_ce", bus.ram_ce, 1);
        bus.dsp_req = 0;
        tick();
        chk("t1_rvld_early", bus.dsp_rvld, 0);
        tick();
        chk("t1_rvld", bus.dsp_rvld, 1);
        chk("t1_rdata", bus.dsp_rdata, 8'hA5);

        // Three-way contention
        bus.dsp_req = 1; bus.dsp_addr = 13'h0010;
        bus.cap_req = 1; bus.cap_addr = 13'h0020; bus.cap_wdata = 8'h11;
        bus.hst_req = 1; bus.hst_we = 1; bus.hst_addr = 13'h0030; bus.hst_wdata = 8'h22;
        tick();
        chk("t2_grants", {seen_d, seen_c, seen_h}, 3'b100);
        chk("t2_addr0", bus.ram_addr, 13'h0010);
        bus.dsp_req = 0;
        tick();
        chk("t2_grants1", {seen_d, seen_c, seen_h}, 3'b010);
        chk("t2_addr1", bus.ram_addr, 13'h0020);
        bus.cap_req = 0;
        tick();
        chk("t2_grants2", {seen_d, seen_c, seen_h}, 3'b001);
        chk("t2_addr2", bus.ram_addr, 13'h0030);
        bus.hst_req = 0;
        repeat (2) tick();

        // Host read of valid data, out-of-range write/read, sticky flag
        bus.hst_req = 1; bus.hst_we = 0; bus.hst_addr = 13'h0020;
        tick();
        bus.hst_req = 0;
        repeat (2) tick();
        chk("t3_hrvld", bus.hst_rvld, 1);
        chk("t3_hrdata", bus.hst_rdata, 8'h11);
        bus.hst_req = 1; bus.hst_we = 1; bus.hst_addr = 13'h1800; bus.hst_wdata = 8'h5A;
        tick();
        chk("t3_oor_gnt", seen_h, 1);
        chk("t3_oor_ce", bus.ram_ce, 0);
        chk("t3_oor_err", bus.oor_err, 1);
        bus.hst_we = 0; bus.hst_addr = 13'h1FFF; bus.err_clr = 1;
        tick();
        chk("t3_set_wins", bus.oor_err, 1);
        bus.hst_req = 0;
        tick();
        chk("t3_clr", bus.oor_err, 0);
        bus.err_clr = 0;
        tick();
        chk("t3_oor_rvld", bus.hst_rvld, 1);
        chk("t3_oor_rdata", bus.hst_rdata, 8'h00);

        // Display streaming against a capture request
        bus.dsp_req = 1; bus.dsp_addr = 13'h0005;
        bus.cap_req = 1; bus.cap_addr = 13'h0006; bus.cap_wdata = 8'h3C;
        denied = 0; granted = 0;
        for (int i = 0; i < 30 && !granted; i++) begin
            tick();
            if (seen_c) granted = 1;
            else denied++;
        end
`ifdef ARB_AGING_EN
        chk("t4_aged_wait", denied, 15);
        chk("t4_aged_gnt", granted, 1);
`else
        chk("t4_starved", granted, 0);
        bus.dsp_req = 0;
        tick();
        chk("t4_after_drop", seen_c, 1);
`endif
        idle_inputs();
        repeat (3) tick();

        // Reset one cycle after a display read transfer
        bus.dsp_req = 1; bus.dsp_addr = 13'h0123;
        tick();
        bus.dsp_req = 0; bus.cap_req = 1; bus.cap_addr = 13'h0007;
        rst_x = 1'b0;
        #1;
        chk("t5_cap_gnt", bus.cap_gnt, 0);
        chk("t5_ram_ce", bus.ram_ce, 0);
        chk("t5_ram_addr", bus.ram_addr, 0);
        chk("t5_dsp_rdata", bus.dsp_rdata, 0);
        chk("t5_hst_rdata", bus.hst_rdata, 0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_x = 1'b1;
        bus.cap_req = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_rvld", bus.dsp_rvld, 0);
        end

        // Randomized traffic: mixed load, then heavy display load
        for (int i = 0; i < 1500; i++) begin
            rand_inputs(50);
            tick();
        end
        for (int i = 0; i < 1500; i++) begin
            rand_inputs(95);
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
